// File: rtl/vta_host_csr.sv
// Host-side CSR responder for the VTA request/response link: decodes single-beat
// read/write requests, holds CTRL/CYCLES/VAL registers, and drives launch/completion.
module vta_host_csr #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int NUM_REGS  = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              dpi_req_valid,
    input  logic                              dpi_req_opcode,
    input  logic [ADDR_BITS-1:0]              dpi_req_addr,
    input  logic [DATA_BITS-1:0]              dpi_req_value,
    output logic                              dpi_req_deq,
    output logic                              dpi_resp_valid,
    output logic [DATA_BITS-1:0]              dpi_resp_bits,
    output logic                              launch,
    input  logic                              finish,
    output logic [(NUM_REGS-2)*DATA_BITS-1:0] vals
);

    localparam int IDX_BITS = ADDR_BITS - 2;

    typedef enum logic [1:0] {IDLE, ACK, GUARD, RESP} state_t;

    state_t                        state;
    state_t                        state_next;
    logic                          op_q;
    logic [IDX_BITS-1:0]           idx_q;
    logic [DATA_BITS-1:0]          value_q;
    logic                          busy;
    logic                          done;
    logic [DATA_BITS-1:0]          cycles;
    logic [NUM_REGS-1:2][DATA_BITS-1:0] vals_q;
    logic [DATA_BITS-1:0]          rdata;
    logic                          commit_wr;
    logic                          commit_rd;
    logic                          ctrl_sel;
    logic                          launch_ok;
    logic                          clear_done;
    logic                          addr_unused;

    // Byte offset within a word carries no meaning for this register file.
    assign addr_unused = ^dpi_req_addr[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dpi_req_valid) state_next = ACK;
            ACK:     state_next = op_q ? GUARD : RESP;
            GUARD:   state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dpi_req_deq    = (state == ACK);
        dpi_resp_valid = (state == RESP);
    end

    assign commit_wr  = (state == ACK) &&  op_q;
    assign commit_rd  = (state == ACK) && !op_q;
    assign ctrl_sel   = (idx_q == '0);
    assign launch_ok  = commit_wr && ctrl_sel && value_q[0] && !busy;
    assign clear_done = commit_wr && ctrl_sel && value_q[1];

    always_comb begin
        rdata = '0;
        if (ctrl_sel) begin
            rdata[1] = done;
        end else if (idx_q == IDX_BITS'(1)) begin
            rdata = cycles;
        end else begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (idx_q == IDX_BITS'(i)) rdata = vals_q[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q          <= 1'b0;
            idx_q         <= '0;
            value_q       <= '0;
            dpi_resp_bits <= '0;
            launch        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cycles        <= '0;
        end else begin
            if (state == IDLE && dpi_req_valid) begin
                op_q    <= dpi_req_opcode;
                idx_q   <= dpi_req_addr[ADDR_BITS-1:2];
                value_q <= dpi_req_value;
            end
            if (commit_rd) dpi_resp_bits <= rdata;
            launch <= launch_ok;
            // A finish edge stops the count without adding the final cycle.
            if (launch_ok) begin
                busy   <= 1'b1;
                cycles <= '0;
            end else if (finish) begin
                busy <= 1'b0;
            end else if (busy) begin
                cycles <= cycles + DATA_BITS'(1);
            end
            if (finish) begin
                done <= 1'b1;
            end else if (clear_done) begin
                done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vals_q <= '0;
        end else if (commit_wr) begin
            for (int unsigned i = 2; i < NUM_REGS; i++) begin
                if (idx_q == IDX_BITS'(i)) vals_q[i] <= value_q;
            end
        end
    end

    assign vals = vals_q;

endmodule

// File: doc/vta_host_csr.md
# vta_host_csr

Register-file responder at the accelerator end of the VTA host request/response interface. Accepts single-beat read/write requests (valid/opcode/addr/value) issued by the host driver, acknowledges each with a one-cycle dequeue pulse, and returns read data with a one-cycle response strobe. Holds the control/status/cycle-count registers and the general value registers exported to the accelerator core, and generates the launch pulse and tracks completion.

## Interface
- ADDR_BITS, 8, request byte-address width
- DATA_BITS, 32, register and data width
- NUM_REGS, 8, total registers (>= 3, <= 2^(ADDR_BITS-2)); indices 2..NUM_REGS-1 are value registers

- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; all state cleared while high
- dpi_req_valid  input  1  request pending; held until dequeued
- dpi_req_opcode  input  1  0 = read, 1 = write
- dpi_req_addr  input  ADDR_BITS  byte address; register index = addr[ADDR_BITS-1:2], addr[1:0] ignored
- dpi_req_value  input  DATA_BITS  write data
- dpi_req_deq  output  1  one-cycle acknowledge of the current request
- dpi_resp_valid  output  1  one-cycle read-data strobe
- dpi_resp_bits  output  DATA_BITS  read data; stable from strobe until the next read response
- launch  output  1  one-cycle start pulse to accelerator
- finish  input  1  accelerator completion pulse
- vals  output  (NUM_REGS-2)*DATA_BITS  value registers, index 2 in LSBs

## Operation
- Register map (index): 0 CTRL, 1 CYCLES, 2..NUM_REGS-1 VAL.
- CTRL write: bit0 = 1 requests launch (self-clearing, reads 0); bit1 = 1 clears DONE (W1C); other bits ignored. CTRL read: {0..., DONE, 0}.
- CYCLES: read-only; cleared on accepted launch, increments by 1 each cycle while BUSY, wraps at 2^DATA_BITS. Writes ignored.
- VAL: read/write, full DATA_BITS, driven continuously on vals.
- Index >= NUM_REGS: write ignored, read returns 0.
- BUSY: set by accepted launch, cleared by finish. Launch requested while BUSY is ignored (no pulse, CYCLES unchanged).
- DONE: sticky; set by finish (even when not BUSY). finish and a DONE-clear write in the same cycle: DONE ends set.
- FSM states: IDLE, ACK, GUARD, RESP.
  - IDLE: dpi_req_valid = 1 at an edge -> latch opcode/addr/value, go ACK.
  - ACK: dpi_req_deq = 1. At the ending edge: write commits (or read data captured into dpi_resp_bits); read -> RESP, write -> GUARD.
  - RESP: dpi_resp_valid = 1; dpi_req_valid ignored; -> IDLE.
  - GUARD: dpi_req_valid ignored (initiator's valid drops one cycle after deq); -> IDLE.
- Read data reflects register contents at the ACK-ending edge (before any same-edge finish/counter update).

## Timing
- Reset values: dpi_req_deq 0, dpi_resp_valid 0, dpi_resp_bits 0, launch 0, all registers 0, BUSY 0, DONE 0, FSM IDLE.
- All outputs registered/state-decoded; no combinational input-to-output path.
- valid sampled at edge E0 -> deq high in cycle E0..E1 -> read resp_valid high in cycle E1..E2; next request sampled no earlier than E2.
- Throughput: one request per 3 cycles.
- launch pulses in the cycle after the CTRL write commits; BUSY set and CYCLES cleared at that same edge; counting starts next cycle.
- finish sampled at edge: BUSY cleared, DONE set at that edge; CYCLES holds final value.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, deq/resp_valid/launch drop, pending request is not committed; initiator must reissue.

## Test plan
- Write VAL idx2 (addr 0x08, value 0xCAFEF00D), read it back -> one deq per request, resp_valid one cycle with 0xCAFEF00D, vals[31:0] = 0xCAFEF00D.
- Read addr 0x1C with NUM_REGS=8 after writing 0x1234 to addr 0x20 -> write ignored; read of 0x20 returns 0; 0x1C returns its own value.
- Write CTRL=1, hold finish low 10 cycles then pulse -> single launch pulse, CYCLES reads 10, CTRL reads 0x2; write CTRL=2 -> CTRL reads 0.
- Write CTRL=1 while BUSY -> no launch pulse, CYCLES keeps counting.
- finish coincident with CTRL=2 write commit -> DONE reads 1.
- Assert reset during ACK of a write to idx3 -> deq drops, idx3 stays 0, FSM IDLE, all outputs 0.
